// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction handshake, register-file port and ALU port of the alu_issue
// sequencer. The slave modport is the sequencer; master is the core/bench side.
interface alu_issue_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 4
) ();

   logic                  instr_valid;
   logic                  instr_ready;
   logic [31:0]           instr;
   logic [REG_ADDR_W-1:0] rf_raddr;
   logic [XLEN-1:0]       rf_rdata;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [XLEN-1:0]       rf_wdata;
   logic [XLEN-1:0]       alu_value1;
   logic [XLEN-1:0]       alu_value2;
   logic [2:0]            alu_func_type;
   logic                  alu_f7_bit;
   logic [XLEN-1:0]       alu_result;
   logic                  done;
   logic                  illegal;

   modport slave (
      input  instr_valid, instr, rf_rdata, alu_result,
      output instr_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
             alu_value1, alu_value2, alu_func_type, alu_f7_bit, done, illegal
   );

   modport master (
      output instr_valid, instr, rf_rdata, alu_result,
      input  instr_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
             alu_value1, alu_value2, alu_func_type, alu_f7_bit, done, illegal
   );

endinterface

// File: rtl/alu_issue.sv
// alu_issue: accepts one RV32E OP/OP-IMM instruction, reads rs1/rs2 through the single
// register-file read port, drives the combinational ALU and writes the result to rd.
// Fixed 5-cycle occupancy: IDLE -> RD_RS1 -> RD_RS2 -> EXEC -> WB (illegal: IDLE -> ILL).
// Optional feature: define ALU_ISSUE_LUI_EN to accept LUI on the same path.
module alu_issue #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 4
) (
   input logic         clk,
   input logic         rst,
   alu_issue_if.slave  bus_io
);

   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;
`ifdef ALU_ISSUE_LUI_EN
   localparam logic [6:0] OpcLui   = 7'b0110111;
`endif

   typedef enum logic [2:0] {
      StIdle,
      StRdRs1,
      StRdRs2,
      StExec,
      StWb,
      StIll
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] op1_q, op1_d;
   logic [XLEN-1:0] result_q, result_d;

   // Output values before the reset override
   logic                  instr_ready_s;
   logic [REG_ADDR_W-1:0] rf_raddr_s;
   logic                  rf_we_s;
   logic [REG_ADDR_W-1:0] rf_waddr_s;
   logic [XLEN-1:0]       rf_wdata_s;
   logic [XLEN-1:0]       alu_value1_s;
   logic [XLEN-1:0]       alu_value2_s;
   logic [2:0]            alu_func_type_s;
   logic                  alu_f7_bit_s;
   logic                  done_s;
   logic                  illegal_s;

   // Fields of the latched instruction
   logic [2:0]            funct3;
   logic [REG_ADDR_W-1:0] rs1, rs2, rd;
   logic [XLEN-1:0]       imm_i;
   logic                  is_op_q;
   logic                  is_lui_q;
   logic                  unused_bits;

   assign funct3  = instr_q[14:12];
   assign rs1     = instr_q[15 +: REG_ADDR_W];
   assign rs2     = instr_q[20 +: REG_ADDR_W];
   assign rd      = instr_q[7 +: REG_ADDR_W];
   assign imm_i   = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
   assign is_op_q = (instr_q[6:0] == OpcOp);
   // Register-index bit 4 only matters at decode time
   assign unused_bits = ^{instr_q[11], instr_q[19]};

`ifdef ALU_ISSUE_LUI_EN
   assign is_lui_q = (instr_q[6:0] == OpcLui);
`else
   assign is_lui_q = 1'b0;
`endif

   // Legality of an incoming instruction word; registers x16..x31 do not exist in RV32E
   function automatic logic decode_legal(logic [31:0] i);
      logic       ok;
      logic [6:0] f7;
      logic [2:0] f3;
      f7 = i[31:25];
      f3 = i[14:12];
      ok = 1'b0;
      case (i[6:0])
         OpcOp: begin
            ok = (f7 == 7'b0000000) ||
                 ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            ok = ok && !i[11] && !i[19] && !i[24];
         end
         OpcOpImm: begin
            ok = !i[11] && !i[19];
            if (f3 == 3'b001) begin
               ok = ok && (f7 == 7'b0000000);
            end
            if (f3 == 3'b101) begin
               ok = ok && ((f7 == 7'b0000000) || (f7 == 7'b0100000));
            end
         end
`ifdef ALU_ISSUE_LUI_EN
         OpcLui: ok = !i[11];
`endif
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Next-state, datapath capture and outputs
   always_comb begin
      state_d         = state_q;
      instr_d         = instr_q;
      op1_d           = op1_q;
      result_d        = result_q;
      instr_ready_s   = 1'b0;
      rf_raddr_s      = '0;
      rf_we_s         = 1'b0;
      rf_waddr_s      = '0;
      rf_wdata_s      = '0;
      alu_value1_s    = '0;
      alu_value2_s    = '0;
      alu_func_type_s = 3'b000;
      alu_f7_bit_s    = 1'b0;
      done_s          = 1'b0;
      illegal_s       = 1'b0;

      case (state_q)
         StIdle: begin
            instr_ready_s = 1'b1;
            if (bus_io.instr_valid) begin
               instr_d = bus_io.instr;
               state_d = decode_legal(bus_io.instr) ? StRdRs1 : StIll;
            end
         end
         StRdRs1: begin
            rf_raddr_s = is_lui_q ? '0 : rs1;
            state_d    = StRdRs2;
         end
         StRdRs2: begin
            op1_d      = bus_io.rf_rdata;
            rf_raddr_s = is_op_q ? rs2 : '0;
            state_d    = StExec;
         end
         StExec: begin
            if (is_lui_q) begin
               alu_value2_s = XLEN'({instr_q[31:12], 12'b0});
            end else begin
               alu_value1_s    = op1_q;
               alu_value2_s    = is_op_q ? bus_io.rf_rdata : imm_i;
               alu_func_type_s = funct3;
               // OP-IMM: bit 30 is an immediate bit except for shifts, so addi never subtracts
               alu_f7_bit_s    = (is_op_q || (funct3 == 3'b101)) ? instr_q[30] : 1'b0;
            end
            result_d = bus_io.alu_result;
            state_d  = StWb;
         end
         StWb: begin
            done_s     = 1'b1;
            rf_we_s    = (rd != '0);
            rf_waddr_s = rd;
            rf_wdata_s = result_q;
            state_d    = StIdle;
         end
         StIll: begin
            illegal_s = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Reset cycle: everything quiet regardless of the current state
      if (rst) begin
         instr_ready_s   = 1'b0;
         rf_raddr_s      = '0;
         rf_we_s         = 1'b0;
         rf_waddr_s      = '0;
         rf_wdata_s      = '0;
         alu_value1_s    = '0;
         alu_value2_s    = '0;
         alu_func_type_s = 3'b000;
         alu_f7_bit_s    = 1'b0;
         done_s          = 1'b0;
         illegal_s       = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         instr_q  <= '0;
         op1_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         op1_q    <= op1_d;
         result_q <= result_d;
      end
   end

   assign bus_io.instr_ready   = instr_ready_s;
   assign bus_io.rf_raddr      = rf_raddr_s;
   assign bus_io.rf_we         = rf_we_s;
   assign bus_io.rf_waddr      = rf_waddr_s;
   assign bus_io.rf_wdata      = rf_wdata_s;
   assign bus_io.alu_value1    = alu_value1_s;
   assign bus_io.alu_value2    = alu_value2_s;
   assign bus_io.alu_func_type = alu_func_type_s;
   assign bus_io.alu_f7_bit    = alu_f7_bit_s;
   assign bus_io.done          = done_s;
   assign bus_io.illegal       = illegal_s;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: bench for alu_issue with a register-file model, a reference ALU and a
// scoreboard. Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_alu_issue;

   typedef struct packed {
      logic        ill;
      logic        we;
      logic [3:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [2:0]  fn;
      logic        f7;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   edges = 0;

   exp_t exp_q[$];
   int   acc_q[$];
   int   acc_prev = 0;
   int   acc_last = 0;

   alu_issue_if #(.XLEN(32), .REG_ADDR_W(4)) bus ();

   alu_issue #(.XLEN(32), .REG_ADDR_W(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   // Register-file model: registered read, x0 reads zero, plus a bench preload port
   logic [31:0] regs [16];
   logic [31:0] rdata_q;
   logic        rf_clr, pl_en;
   logic [3:0]  pl_addr;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      rdata_q <= (bus.rf_raddr == 4'd0) ? 32'd0 : regs[bus.rf_raddr];
      if (rf_clr) begin
         for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
      end else begin
         if (bus.rf_we && bus.rf_waddr != 4'd0) regs[bus.rf_waddr] <= bus.rf_wdata;
         if (pl_en) regs[pl_addr] <= pl_data;
      end
   end
   assign bus.rf_rdata = rdata_q;

   // Reference ALU
   logic [31:0] alu_res;
   always_comb begin
      alu_res = 32'd0;
      case (bus.alu_func_type)
         3'b000: alu_res = bus.alu_f7_bit ? bus.alu_value1 - bus.alu_value2
                                          : bus.alu_value1 + bus.alu_value2;
         3'b001: alu_res = bus.alu_value1 << bus.alu_value2[4:0];
         3'b010: alu_res = {31'd0, $signed(bus.alu_value1) < $signed(bus.alu_value2)};
         3'b011: alu_res = {31'd0, bus.alu_value1 < bus.alu_value2};
         3'b100: alu_res = bus.alu_value1 ^ bus.alu_value2;
         3'b101: alu_res = bus.alu_f7_bit ? 32'($signed(bus.alu_value1) >>> bus.alu_value2[4:0])
                                          : bus.alu_value1 >> bus.alu_value2[4:0];
         3'b110: alu_res = bus.alu_value1 | bus.alu_value2;
         default: alu_res = bus.alu_value1 & bus.alu_value2;
      endcase
   end
   assign bus.alu_result = alu_res;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(logic ill, logic we, logic [3:0] wa, logic [31:0] wd,
                               logic [31:0] v1, logic [31:0] v2, logic [2:0] fn, logic f7);
      exp_t e;
      e.ill = ill; e.we = we; e.waddr = wa; e.wdata = wd;
      e.v1 = v1; e.v2 = v2; e.fn = fn; e.f7 = f7;
      return e;
   endfunction

   function automatic exp_t mk_ill();
      return mk(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0);
   endfunction

   // Monitor: tracks acceptances, captures EXEC-cycle ALU drive, checks each retirement
   logic [31:0] cap_v1, cap_v2;
   logic [2:0]  cap_fn;
   logic        cap_f7;
   logic        chk_rdy = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      int   a;
      int   lat;
      if (rst) begin
         acc_q.delete();
         chk_rdy = 1'b0;
      end else begin
         if (chk_rdy) begin
            chk("ready_again", {31'd0, bus.instr_ready}, 32'd1);
            chk("single_pulse", {30'd0, bus.done, bus.illegal}, 32'd0);
            chk_rdy = 1'b0;
         end
         if (bus.instr_valid && bus.instr_ready) begin
            acc_q.push_back(edges);
            acc_prev = acc_last;
            acc_last = edges;
         end
         if (acc_q.size() > 0 && edges - acc_q[0] == 3) begin
            cap_v1 = bus.alu_value1;
            cap_v2 = bus.alu_value2;
            cap_fn = bus.alu_func_type;
            cap_f7 = bus.alu_f7_bit;
         end else begin
            chk("alu_zero_outside_exec",
                {31'd0, |{bus.alu_value1, bus.alu_value2, bus.alu_func_type, bus.alu_f7_bit}},
                32'd0);
         end
         if (!bus.done) begin
            chk("wb_zero_outside_wb", {31'd0, |{bus.rf_we, bus.rf_waddr, bus.rf_wdata}}, 32'd0);
         end
         if (bus.done || bus.illegal) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_retire: got done=%0d illegal=%0d expected none",
                        bus.done, bus.illegal);
            end else begin
               e   = exp_q.pop_front();
               a   = acc_q.pop_front();
               lat = edges - a;
               chk("retire_kind", {31'd0, bus.illegal}, {31'd0, e.ill});
               if (e.ill) begin
                  chk("ill_latency", lat, 32'd1);
                  chk("ill_no_done_we", {30'd0, bus.done, bus.rf_we}, 32'd0);
               end else begin
                  chk("done_latency", lat, 32'd4);
                  chk("rf_we", {31'd0, bus.rf_we}, {31'd0, e.we});
                  chk("rf_waddr", {28'd0, bus.rf_waddr}, {28'd0, e.waddr});
                  chk("rf_wdata", bus.rf_wdata, e.wdata);
                  chk("alu_value1", cap_v1, e.v1);
                  chk("alu_value2", cap_v2, e.v2);
                  chk("alu_func_type", {29'd0, cap_fn}, {29'd0, e.fn});
                  chk("alu_f7_bit", {31'd0, cap_f7}, {31'd0, e.f7});
               end
               chk_rdy = 1'b1;
            end
         end
      end
   end

   task automatic preload(input logic [3:0] ad, input logic [31:0] d);
      @(posedge clk); #1;
      pl_en = 1'b1; pl_addr = ad; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // Wait at negedges until ready (bounded); the following posedge accepts
   task automatic wait_ready(input string nm);
      int n = 0;
      @(negedge clk);
      while (!bus.instr_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!bus.instr_ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [31:0] ins);
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      wait_ready("send");
      bus.instr_valid = 1'b0;
      bus.instr       = 32'h0000_0073; // garbage while busy
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         chk("retire_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic run(input logic [31:0] ins, input exp_t e);
      exp_q.push_back(e);
      send(ins);
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; rf_clr = 1'b1; pl_en = 1'b0; pl_addr = 4'd0; pl_data = 32'd0;
      bus.instr_valid = 1'b1; bus.instr = 32'h002081B3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", {31'd0, bus.instr_ready}, 32'd0);
      chk("reset_pulses", {29'd0, bus.done, bus.illegal, bus.rf_we}, 32'd0);
      chk("reset_buses", {31'd0, |{bus.rf_raddr, bus.rf_waddr, bus.rf_wdata, bus.alu_value1,
                                   bus.alu_value2, bus.alu_func_type, bus.alu_f7_bit}}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; rf_clr = 1'b0; bus.instr_valid = 1'b0;
      @(negedge clk);
      chk("idle_ready", {31'd0, bus.instr_ready}, 32'd1);
      @(posedge clk); #1;

      preload(4'd1, 32'd5);
      preload(4'd2, 32'd3);
      // add x3,x1,x2
      run(32'h002081B3, mk(1'b0, 1'b1, 4'd3, 32'd8, 32'd5, 32'd3, 3'b000, 1'b0));
      // sub x4,x1,x2
      run(32'h40208233, mk(1'b0, 1'b1, 4'd4, 32'd2, 32'd5, 32'd3, 3'b000, 1'b1));
      preload(4'd1, 32'h8000_0000);
      // srai x5,x1,1
      run(32'h4010D293, mk(1'b0, 1'b1, 4'd5, 32'hC000_0000, 32'h8000_0000, 32'h401, 3'b101, 1'b1));
      // xor x9,x1,x2
      run(32'h0020C4B3, mk(1'b0, 1'b1, 4'd9, 32'h8000_0003, 32'h8000_0000, 32'd3, 3'b100, 1'b0));
      // addi x6,x0,-1
      run(32'hFFF00313, mk(1'b0, 1'b1, 4'd6, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 3'b000, 1'b0));
      // addi x0,x0,1: retires without a write
      run(32'h00100013, mk(1'b0, 1'b0, 4'd0, 32'd1, 32'd0, 32'd1, 3'b000, 1'b0));
      // add x16,x1,x2 / branch opcode / OP with funct7=0100000 on sll
      run(32'h00208833, mk_ill());
      run(32'h00208063, mk_ill());
      run(32'h40209033, mk_ill());
`ifdef ALU_ISSUE_LUI_EN
      run(32'h123453B7, mk(1'b0, 1'b1, 4'd7, 32'h1234_5000, 32'd0, 32'h1234_5000, 3'b000, 1'b0));
`else
      run(32'h123453B7, mk_ill());
`endif
      chk("rf_x5", regs[5], 32'hC000_0000);

      // Reset in EXEC of add x11,x1,x2: no write, no done
      send(32'h002085B3);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_quiet", {31'd0, |{bus.instr_ready, bus.done, bus.rf_we, bus.alu_value1,
                                    bus.alu_value2, bus.alu_func_type, bus.alu_f7_bit}}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_idle", {30'd0, bus.instr_ready, bus.done}, 32'd2);
      repeat (8) @(posedge clk);
      #1;
      chk("midrst_no_write", regs[11], 32'd0);

      // Back-to-back with valid held high
      preload(4'd1, 32'd5);
      exp_q.push_back(mk(1'b0, 1'b1, 4'd3, 32'd8, 32'd5, 32'd3, 3'b000, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b1, 4'd4, 32'd2, 32'd5, 32'd3, 3'b000, 1'b1));
      bus.instr = 32'h002081B3;
      bus.instr_valid = 1'b1;
      wait_ready("b2b_first");
      bus.instr = 32'h40208233;
      wait_ready("b2b_second");
      bus.instr_valid = 1'b0;
      bus.instr = 32'h0000_0073;
      wait_done();
      chk("b2b_spacing", acc_last - acc_prev, 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
